inst_sequencer: RTL and testbench

//  Timing/sequence controller for the basic-computer datapath. Steps a 4-bit

---
 rtl/inst_sequencer.sv | 152 +++++++++++++++
 tb/tb_inst_sequencer.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/inst_sequencer.sv
// rtl/inst_sequencer.sv - instruction timing sequencer: slot counter, one-hot strobes, opcode decode, start/halt.
// Optional interrupt cycle enabled by defining INST_SEQ_INTR_EN.
module inst_sequencer #(
    parameter int RREF_LAST = 7,
    parameter int MREF_LAST = 11
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    input  logic [15:0] ir_odat,
`ifdef INST_SEQ_INTR_EN
    input  logic        irq,
    output logic        int_cycle,
`endif
    output logic [15:0] dec_signal,
    output logic [7:0]  dec,
    output logic [3:0]  sc,
    output logic        running,
    output logic        halted
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2,
        S_INT  = 2'd3
    } state_t;

    localparam logic [3:0] RREF_END = RREF_LAST[3:0];
    localparam logic [3:0] MREF_END = MREF_LAST[3:0];

    state_t     state_q, state_d;
    logic [3:0] sc_q, sc_d;
    logic [7:0] dec_q, dec_d;
    logic       hlt_q, hlt_d;
    logic [3:0] last_slot;
    logic       hlt_sample;
    logic       inst_end;

`ifdef INST_SEQ_INTR_EN
    logic       ien_q, ien_d;
    logic       io_slot;
    logic       ir_unused;
    assign ir_unused = ^{ir_odat[11:8], ir_odat[5:1]};
`else
    logic       ir_unused;
    assign ir_unused = ^{ir_odat[11:1]};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            sc_q    <= 4'd0;
            dec_q   <= 8'h00;
            hlt_q   <= 1'b0;
`ifdef INST_SEQ_INTR_EN
            ien_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sc_q    <= sc_d;
            dec_q   <= dec_d;
            hlt_q   <= hlt_d;
`ifdef INST_SEQ_INTR_EN
            ien_q   <= ien_d;
`endif
        end
    end

    // dec[7] is the current instruction's class from slot 4 onward, which is
    // all that matters since every end slot lies beyond slot 3.
    assign last_slot  = dec_q[7] ? RREF_END : MREF_END;
    assign hlt_sample = (sc_q == 4'd6) && dec_q[7] && !ir_odat[15] && ir_odat[0];
    assign inst_end   = (sc_q == last_slot) || (sc_q == 4'hF);
`ifdef INST_SEQ_INTR_EN
    assign io_slot    = (sc_q == 4'd6) && dec_q[7] && ir_odat[15];
`endif

    always_comb begin
        state_d = state_q;
        sc_d    = sc_q;
        dec_d   = dec_q;
        hlt_d   = hlt_q;
`ifdef INST_SEQ_INTR_EN
        ien_d   = ien_q;
`endif
        case (state_q)
            S_IDLE, S_HALT: begin
                sc_d  = 4'd0;
                hlt_d = 1'b0;
                if (run) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (sc_q == 4'd3) begin
                    dec_d = 8'h01 << ir_odat[14:12];
                end
                if (hlt_sample) begin
                    hlt_d = 1'b1;
                end
`ifdef INST_SEQ_INTR_EN
                // IOF is checked last so it wins when both bits are set.
                if (io_slot && ir_odat[7]) begin
                    ien_d = 1'b1;
                end
                if (io_slot && ir_odat[6]) begin
                    ien_d = 1'b0;
                end
`endif
                if (inst_end) begin
                    sc_d  = 4'd0;
                    hlt_d = 1'b0;
                    if (hlt_q || hlt_sample) begin
                        state_d = S_HALT;
`ifdef INST_SEQ_INTR_EN
                    end else if (ien_q && irq) begin
                        state_d = S_INT;
`endif
                    end
                end else begin
                    sc_d = sc_q + 4'd1;
                end
            end
`ifdef INST_SEQ_INTR_EN
            S_INT: begin
                if (sc_q == 4'd5) begin
                    sc_d    = 4'd0;
                    ien_d   = 1'b0;
                    state_d = S_RUN;
                end else begin
                    sc_d = sc_q + 4'd1;
                end
            end
`endif
            default: begin
                state_d = S_IDLE;
                sc_d    = 4'd0;
            end
        endcase
    end

    assign running    = (state_q == S_RUN) || (state_q == S_INT);
    assign halted     = (state_q == S_HALT);
    assign dec_signal = running ? (16'h0001 << sc_q) : 16'h0000;
    assign dec        = dec_q;
    assign sc         = sc_q;
`ifdef INST_SEQ_INTR_EN
    assign int_cycle  = (state_q == S_INT);
`endif

endmodule

// File: tb/tb_inst_sequencer.sv
// tb/tb_inst_sequencer.sv - scoreboard bench for inst_sequencer with a slot-list reference model.
// Interrupt scenario runs when INST_SEQ_INTR_EN is defined.
module tb_inst_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        run = 1'b0;
    logic [15:0] ir_odat = 16'h0000;
    logic        irq = 1'b0;
    logic        int_cycle;
    logic [15:0] dec_signal;
    logic [7:0]  dec;
    logic [3:0]  sc;
    logic        running;
    logic        halted;

    inst_sequencer #(.RREF_LAST(7), .MREF_LAST(11)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .run        (run),
        .ir_odat    (ir_odat),
`ifdef INST_SEQ_INTR_EN
        .irq        (irq),
        .int_cycle  (int_cycle),
`endif
        .dec_signal (dec_signal),
        .dec        (dec),
        .sc         (sc),
        .running    (running),
        .halted     (halted)
    );

`ifndef INST_SEQ_INTR_EN
    assign int_cycle = 1'b0;
`endif

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  sc;
        logic [15:0] ds;
        logic [7:0]  dec;
        logic        ic;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          passes = 0;
    logic [7:0]  prev_dec = 8'h00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act === expv) passes++;
        else $display("FAIL %s actual=%h required=%h", name, act, expv);
    endtask

    function automatic int last_of(input logic [15:0] ir);
        return (ir[14:12] == 3'd7) ? 7 : 11;
    endfunction

    // Expected strobes for one instruction: slots 0..upto; opcode decode
    // becomes visible from slot 4, earlier slots still show the previous one.
    task automatic push_instr(input logic [15:0] ir, input int upto);
        logic [7:0] nd;
        exp_t e;
        nd = 8'h01 << ir[14:12];
        for (int s = 0; s <= upto; s++) begin
            e.sc  = 4'(s);
            e.ds  = 16'h0001 << s;
            e.dec = (s >= 4) ? nd : prev_dec;
            e.ic  = 1'b0;
            exp_q.push_back(e);
        end
        if (upto >= 3) prev_dec = nd;
    endtask

    task automatic issue(input logic [15:0] ir, input logic start, input logic hold, input logic irqv);
        ir_odat = ir;
        run     = start | hold;
        push_instr(ir, last_of(ir));
        @(negedge clk);
        run = hold;
        irq = irqv;
        repeat (last_of(ir)) @(negedge clk);
    endtask

    function automatic logic [15:0] rand_instr();
        logic [15:0] r;
        r = 16'($urandom);
        case ($urandom_range(0, 2))
            0: begin
                r[14:12] = 3'($urandom_range(0, 6));
            end
            1: begin
                r[15]    = 1'b0;
                r[14:12] = 3'd7;
                r[0]     = 1'b0;
            end
            default: begin
                r[15]    = 1'b1;
                r[14:12] = 3'd7;
            end
        endcase
        return r;
    endfunction

    function automatic logic [15:0] rand_mref();
        logic [15:0] r;
        r = 16'($urandom);
        r[14:12] = 3'($urandom_range(0, 6));
        return r;
    endfunction

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (rst_n && running) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_run_cycle", {15'd0, running, sc, dec_signal}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("slot", {3'd0, int_cycle, dec, dec_signal, sc},
                    {3'd0, e.ic, e.dec, e.ds, e.sc});
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] ir;
        exp_t e;

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("reset_idle", {running, halted, sc, dec_signal, dec}, 32'd0);
        end

        issue(16'h2005, 1'b1, 1'b0, 1'b0);
        issue(16'h7800, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 24; i++) begin
            issue(rand_instr(), 1'b0, 1'($urandom_range(0, 1)), 1'b0);
        end

        // run held high through HLT, including the end edge: halt must win
        issue(16'h7001, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        run = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("halt_state", {running, halted, sc, dec_signal, dec},
                {1'b0, 1'b1, 4'd0, 16'h0000, 8'h80});
        end

        issue(rand_mref(), 1'b1, 1'b0, 1'b0);
        issue(rand_instr(), 1'b0, 1'b0, 1'b0);

`ifdef INST_SEQ_INTR_EN
        issue(16'hF080, 1'b0, 1'b0, 1'b0);
        issue(rand_mref(), 1'b0, 1'b0, 1'b1);
        for (int s = 0; s < 6; s++) begin
            e.sc  = 4'(s);
            e.ds  = 16'h0001 << s;
            e.dec = prev_dec;
            e.ic  = 1'b1;
            exp_q.push_back(e);
        end
        repeat (6) @(negedge clk);
        // IEN is cleared by the interrupt cycle, so irq still high is ignored
        issue(rand_mref(), 1'b0, 1'b0, 1'b1);
        issue(16'h7800, 1'b0, 1'b0, 1'b0);
`endif

        ir = rand_mref();
        ir_odat = ir;
        push_instr(ir, 9);
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk("async_reset", {running, halted, sc, dec_signal, dec}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        prev_dec = 8'h00;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("post_reset_idle", {running, halted, sc, dec_signal, dec}, 32'd0);
        end
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
